// File: rtl/nv_nvdla_cdp_wdma_wr_arb.sv
// rtl/nv_nvdla_cdp_wdma_wr_arb.sv - two-client round-robin write-request arbiter with packet locking
// Commands win at packet boundaries; the owner keeps the output until its last data beat is accepted.
module nv_nvdla_cdp_wdma_wr_arb #(
    parameter int PW      = 515,
    parameter int LEN_LSB = 64,
    parameter int LEN_W   = 13
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          op_en,
    input  logic          c0_req_vld,
    input  logic [PW-1:0] c0_req_pd,
    output logic          c0_req_rdy,
    input  logic          c1_req_vld,
    input  logic [PW-1:0] c1_req_pd,
    output logic          c1_req_rdy,
    output logic          dma_wr_req_vld,
    output logic [PW-1:0] dma_wr_req_pd,
    input  logic          dma_wr_req_rdy,
    output logic          arb_busy,
    output logic          pkt_done,
    output logic          proto_err
);

    typedef enum logic {ST_IDLE, ST_DATA} state_t;

    state_t           state_q;
    logic             owner_q;
    logic             last_gnt_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic             proto_err_q;
    logic             pkt_done_q;

    logic             c0_is_data;
    logic             c1_is_data;
    logic             c0_elig;
    logic             c1_elig;
    logic             win;
    logic             sel;
    logic             sel_vld;
    logic [PW-1:0]    sel_pd;
    logic             out_vld;
    logic             err_set;
    logic             xfer;

    assign c0_is_data = c0_req_pd[PW-1];
    assign c1_is_data = c1_req_pd[PW-1];
    assign c0_elig    = c0_req_vld && !c0_is_data && op_en;
    assign c1_elig    = c1_req_vld && !c1_is_data && op_en;

    // On a tie the client that did not win last time goes; otherwise the only eligible one.
    assign win     = (c0_elig && c1_elig) ? ~last_gnt_q : c1_elig;
    assign sel     = (state_q == ST_DATA) ? owner_q : win;
    assign sel_pd  = sel ? c1_req_pd : c0_req_pd;
    assign sel_vld = sel ? c1_req_vld : c0_req_vld;

    always_comb begin
        out_vld = 1'b0;
        err_set = 1'b0;
        if (state_q == ST_IDLE) begin
            out_vld = c0_elig || c1_elig;
            err_set = (c0_req_vld && c0_is_data) || (c1_req_vld && c1_is_data);
        end else begin
            out_vld = sel_vld && sel_pd[PW-1];
            err_set = sel_vld && !sel_pd[PW-1];
        end
    end

    assign dma_wr_req_vld = nvdla_core_rstn && out_vld;
    assign dma_wr_req_pd  = sel_pd;
    assign c0_req_rdy     = dma_wr_req_vld && !sel && dma_wr_req_rdy;
    assign c1_req_rdy     = dma_wr_req_vld && sel && dma_wr_req_rdy;
    assign arb_busy       = nvdla_core_rstn && (state_q == ST_DATA);
    assign pkt_done       = pkt_done_q;
    assign proto_err      = proto_err_q;
    assign xfer           = dma_wr_req_vld && dma_wr_req_rdy;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b1;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            if (err_set) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        owner_q    <= sel;
                        last_gnt_q <= sel;
                        beat_cnt_q <= sel_pd[LEN_LSB +: LEN_W];
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // beat_cnt holds beats remaining after the current one, so it never wraps.
                    if (xfer) begin
                        if (beat_cnt_q == '0) begin
                            state_q    <= ST_IDLE;
                            pkt_done_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cdp_wdma_wr_arb.sv
// tb/tb_nv_nvdla_cdp_wdma_wr_arb.sv - directed self-checking bench for the CDP WDMA write arbiter
module tb_nv_nvdla_cdp_wdma_wr_arb;

    localparam int PW      = 515;
    localparam int LEN_LSB = 64;
    localparam int LEN_W   = 13;

    logic          clk;
    logic          rstn;
    logic          op_en;
    logic          c0_vld;
    logic [PW-1:0] c0_pd;
    logic          c0_rdy;
    logic          c1_vld;
    logic [PW-1:0] c1_pd;
    logic          c1_rdy;
    logic          dma_vld;
    logic [PW-1:0] dma_pd;
    logic          dma_rdy;
    logic          busy;
    logic          pdone;
    logic          perr;

    int checks = 0;
    int errors = 0;

    nv_nvdla_cdp_wdma_wr_arb #(.PW(PW), .LEN_LSB(LEN_LSB), .LEN_W(LEN_W)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_en           (op_en),
        .c0_req_vld      (c0_vld),
        .c0_req_pd       (c0_pd),
        .c0_req_rdy      (c0_rdy),
        .c1_req_vld      (c1_vld),
        .c1_req_pd       (c1_pd),
        .c1_req_rdy      (c1_rdy),
        .dma_wr_req_vld  (dma_vld),
        .dma_wr_req_pd   (dma_pd),
        .dma_wr_req_rdy  (dma_rdy),
        .arb_busy        (busy),
        .pkt_done        (pdone),
        .proto_err       (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input logic typ, input int len, input int tag);
        logic [PW-1:0] p;
        p = '0;
        p[PW-1] = typ;
        p[LEN_LSB +: LEN_W] = len[LEN_W-1:0];
        p[15:0] = tag[15:0];
        return p;
    endfunction

    // Item i of a client stream in the round-robin test: cmd len=2 then three data beats, repeating.
    function automatic logic [PW-1:0] rr_item(input int c, input int i);
        int k;
        k = i % 4;
        return mk(k != 0, (k == 0) ? 2 : 0, c * 256 + (i / 4) * 16 + k);
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int i0, i1, n, cyc, acc;
        logic a0, a1, r;

        rstn = 1'b0; op_en = 1'b1; dma_rdy = 1'b1;
        c0_vld = 1'b1; c0_pd = mk(0, 0, 'h01);
        c1_vld = 1'b0; c1_pd = '0;
        tick(); tick();
        chk("rst_vld", dma_vld, 0);
        chk("rst_c0_rdy", c0_rdy, 0);
        chk("rst_c1_rdy", c1_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", perr, 0);
        chk("rst_pdone", pdone, 0);

        // single packet, len=0
        rstn = 1'b1; #1;
        chk("p1_cmd_vld", dma_vld, 1);
        chk("p1_cmd_pd", dma_pd, mk(0, 0, 'h01));
        chk("p1_cmd_c0_rdy", c0_rdy, 1);
        chk("p1_cmd_c1_rdy", c1_rdy, 0);
        tick();
        chk("p1_busy", busy, 1);
        c0_pd = mk(1, 0, 'h02); #1;
        chk("p1_dat_vld", dma_vld, 1);
        chk("p1_dat_pd", dma_pd, mk(1, 0, 'h02));
        chk("p1_dat_c0_rdy", c0_rdy, 1);
        tick();
        chk("p1_pdone", pdone, 1);
        chk("p1_idle", busy, 0);
        c0_vld = 1'b0;
        tick();
        chk("p1_pdone_clr", pdone, 0);

        // round robin with both clients always requesting
        rstn = 1'b0; tick(); rstn = 1'b1;
        i0 = 0; i1 = 0; n = 0; cyc = 0;
        c0_vld = 1'b1; c1_vld = 1'b1;
        while (n < 16 && cyc < 40) begin
            c0_pd = rr_item(0, i0);
            c1_pd = rr_item(1, i1);
            #1;
            a0 = c0_rdy; a1 = c1_rdy;
            chk("rr_onehot", a0 && a1, 0);
            if (dma_vld && dma_rdy) begin
                chk("rr_pd", dma_pd, rr_item((n / 4) % 2, ((n / 4) / 2) * 4 + n % 4));
                n++;
            end
            tick();
            if (a0) i0++;
            if (a1) i1++;
            cyc++;
        end
        chk("rr_count", n, 16);
        c0_vld = 1'b0; c1_vld = 1'b0;

        // downstream stalls mid-packet, len=3
        c0_vld = 1'b1; c0_pd = mk(0, 3, 'h30); #1;
        chk("st_cmd_vld", dma_vld, 1);
        tick();
        acc = 0; cyc = 0;
        while (acc < 4 && cyc < 20) begin
            c0_pd = mk(1, 0, 'h31 + acc);
            dma_rdy = (cyc % 2 == 0);
            #1;
            chk("st_vld", dma_vld, 1);
            chk("st_pd", dma_pd, mk(1, 0, 'h31 + acc));
            chk("st_c0_rdy", c0_rdy, dma_rdy);
            chk("st_busy", busy, 1);
            r = dma_rdy;
            tick();
            if (r) acc++;
            cyc++;
        end
        chk("st_beats", acc, 4);
        chk("st_pdone", pdone, 1);
        chk("st_idle", busy, 0);
        chk("st_perr", perr, 0);
        c0_vld = 1'b0; dma_rdy = 1'b1;

        // owner presents a command while in DATA
        c0_vld = 1'b1; c0_pd = mk(0, 1, 'h40); #1;
        tick();
        c0_pd = mk(0, 1, 'h41); #1;
        chk("pe_vld", dma_vld, 0);
        chk("pe_c0_rdy", c0_rdy, 0);
        tick();
        chk("pe_perr", perr, 1);
        c0_pd = mk(1, 0, 'h42); #1;
        chk("pe_dat_pd", dma_pd, mk(1, 0, 'h42));
        tick();
        c0_pd = mk(1, 0, 'h43);
        tick();
        chk("pe_pdone", pdone, 1);
        chk("pe_sticky", perr, 1);
        c0_vld = 1'b0; c1_vld = 1'b1; c1_pd = mk(1, 0, 'h44); #1;
        chk("pe_idle_dat_vld", dma_vld, 0);
        chk("pe_idle_dat_rdy", c1_rdy, 0);
        tick();
        chk("pe_sticky2", perr, 1);
        c1_vld = 1'b0;

        // op_en drops mid-packet
        c0_vld = 1'b1; c0_pd = mk(0, 1, 'h50); #1;
        tick();
        op_en = 1'b0; c1_vld = 1'b1; c1_pd = mk(0, 0, 'h60); c0_pd = mk(1, 0, 'h51); #1;
        chk("op_d0_vld", dma_vld, 1);
        chk("op_d0_pd", dma_pd, mk(1, 0, 'h51));
        chk("op_d0_c0_rdy", c0_rdy, 1);
        chk("op_d0_c1_rdy", c1_rdy, 0);
        tick();
        c0_pd = mk(1, 0, 'h52); #1;
        chk("op_d1_pd", dma_pd, mk(1, 0, 'h52));
        tick();
        chk("op_pdone", pdone, 1);
        chk("op_idle", busy, 0);
        c0_vld = 1'b0; #1;
        chk("op_hold_vld", dma_vld, 0);
        chk("op_hold_c1_rdy", c1_rdy, 0);
        tick();
        chk("op_hold_busy", busy, 0);
        chk("op_hold_vld2", dma_vld, 0);
        op_en = 1'b1; #1;
        chk("op_gnt_vld", dma_vld, 1);
        chk("op_gnt_pd", dma_pd, mk(0, 0, 'h60));
        chk("op_gnt_c1_rdy", c1_rdy, 1);
        tick();
        chk("op_c1_busy", busy, 1);
        c1_pd = mk(1, 0, 'h61);
        tick();
        chk("op_c1_pdone", pdone, 1);
        c1_vld = 1'b0;

        // reset mid-packet after one of four beats
        c0_vld = 1'b1; c0_pd = mk(0, 3, 'h70); #1;
        tick();
        c0_pd = mk(1, 0, 'h71);
        tick();
        chk("rm_busy", busy, 1);
        rstn = 1'b0; c0_pd = mk(1, 0, 'h72); #1;
        chk("rm_vld", dma_vld, 0);
        chk("rm_c0_rdy", c0_rdy, 0);
        chk("rm_busy_rst", busy, 0);
        tick();
        rstn = 1'b1; c0_vld = 1'b0; c1_vld = 1'b1; c1_pd = mk(0, 0, 'h80); #1;
        chk("rm_c1_vld", dma_vld, 1);
        chk("rm_c1_pd", dma_pd, mk(0, 0, 'h80));
        chk("rm_c1_rdy", c1_rdy, 1);
        chk("rm_idle", busy, 0);
        chk("rm_perr_clr", perr, 0);
        tick();
        chk("rm_c1_busy", busy, 1);
        c1_pd = mk(1, 0, 'h81);
        tick();
        chk("rm_c1_pdone", pdone, 1);
        c1_vld = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
